// File: rtl/entity_scanline_prefetch_pkg.sv
// Shared constants, entity field layout and FSM encodings for the scanline sprite prefetcher.
package entity_scanline_prefetch_pkg;

  localparam int UPSCALE  = 5;
  localparam int TILE_PX  = 8 * UPSCALE;
  localparam int TILES_H  = 16;
  localparam int TILE_ROWS = 12;
  localparam int ENT_W    = 14;

  localparam int ID_LSB     = 10;
  localparam int ORIENT_LSB = 8;
  localparam int LOC_LSB    = 0;

  localparam logic [3:0] ID_UNUSED = 4'hF;
  // Locations at or beyond this index lie below the visible playfield.
  localparam int LOC_LIMIT = TILE_ROWS * TILES_H;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] orient;
    logic [7:0] loc;
  } entity_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } fsm_state_t;

  function automatic logic [3:0] tile_of(input logic [9:0] v);
    return 4'(v / 10'(TILE_PX));
  endfunction

  function automatic logic [2:0] sub_of(input logic [9:0] v);
    return 3'((v % 10'(TILE_PX)) / 10'(UPSCALE));
  endfunction

endpackage

// File: rtl/entity_scanline_prefetch_slot_bank.sv
// Double-buffered sprite row slots: shadow bank filled during blanking, active bank read by the pixel path.
// Optional ENT_COLLISION_EN adds a flag for two overlapping sprites both drawing black.
module entity_slot_bank
  import entity_scanline_prefetch_pkg::*;
#(
  parameter int NUM_ENT = 8,
  parameter int IDX_W   = $clog2(NUM_ENT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [3:0]       wr_col,
  input  logic [7:0]       wr_row,
  input  logic             clear,
  input  logic             swap,
  input  logic [3:0]       tc,
  input  logic [2:0]       px,
  output logic             hit,
  output logic             pix
`ifdef ENT_COLLISION_EN
  ,
  output logic             black_pair
`endif
);

  logic [NUM_ENT-1:0] shadow_valid;
  logic [NUM_ENT-1:0] active_valid;
  logic [3:0]         shadow_col [NUM_ENT];
  logic [7:0]         shadow_row [NUM_ENT];
  logic [3:0]         active_col [NUM_ENT];
  logic [7:0]         active_row [NUM_ENT];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_valid <= '0;
      active_valid <= '0;
    end else begin
      if (swap) active_valid <= shadow_valid;
      if (clear) shadow_valid <= '0;
      else if (wr_en) shadow_valid[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      shadow_col[wr_idx] <= wr_col;
      shadow_row[wr_idx] <= wr_row;
    end
    if (swap) begin
      for (int i = 0; i < NUM_ENT; i++) begin
        active_col[i] <= shadow_col[i];
        active_row[i] <= shadow_row[i];
      end
    end
  end

  // Walk from the top index down so the lowest-index slot wins.
  always_comb begin
    hit = 1'b0;
    pix = 1'b0;
    for (int i = NUM_ENT - 1; i >= 0; i--) begin
      if (active_valid[i] && active_col[i] == tc) begin
        hit = 1'b1;
        pix = active_row[i][px];
      end
    end
  end

`ifdef ENT_COLLISION_EN
  always_comb begin
    logic seen;
    seen       = 1'b0;
    black_pair = 1'b0;
    for (int i = 0; i < NUM_ENT; i++) begin
      if (active_valid[i] && active_col[i] == tc && !active_row[i][px]) begin
        black_pair = black_pair | seen;
        seen       = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/entity_scanline_prefetch.sv
// Scanline sprite prefetcher: fetches visible sprite rows during h-blank and renders 1-bit colour.
// Build option ENT_COLLISION_EN adds the registered collision output.
module entity_scanline_prefetch
  import entity_scanline_prefetch_pkg::*;
#(
  parameter int NUM_ENT  = 8,
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_ENT*ENT_W-1:0] entities,
  input  logic [9:0]               counter_H,
  input  logic [9:0]               counter_V,
  output logic                     rom_req,
  output logic [3:0]               rom_sprite_id,
  output logic [1:0]               rom_orient,
  output logic [2:0]               rom_line,
  input  logic [7:0]               rom_data,
  output logic                     colour,
  output logic                     prefetch_busy
`ifdef ENT_COLLISION_EN
  ,
  output logic                     collision
`endif
);

  localparam int IDX_W = $clog2(NUM_ENT);

  fsm_state_t       state;
  logic [IDX_W-1:0] idx;
  logic [3:0]       req_col;

  logic [9:0] v_next;
  logic [3:0] t_row;
  logic [2:0] line_idx;
  entity_t    ent;
  logic       ent_match;
  logic       last_ent;
  logic       line_start;
  logic       line_end;

  assign v_next     = (counter_V == 10'(V_TOTAL - 1)) ? 10'd0 : counter_V + 10'd1;
  assign t_row      = tile_of(v_next);
  assign line_idx   = sub_of(v_next);
  assign ent        = entity_t'(entities[idx*ENT_W +: ENT_W]);
  assign last_ent   = (idx == IDX_W'(NUM_ENT - 1));
  assign line_start = (counter_H == 10'(H_ACTIVE));
  assign line_end   = (counter_H == 10'(H_TOTAL - 1));

  assign ent_match = (state == ST_SCAN) && (ent.id != ID_UNUSED) &&
                     (ent.loc < 8'(LOC_LIMIT)) && (ent.loc[7:4] == t_row);

  // The ROM samples the request in the SCAN cycle and answers during WAIT.
  assign rom_req       = ent_match;
  assign rom_sprite_id = ent_match ? ent.id : 4'd0;
  assign rom_orient    = ent_match ? ent.orient : 2'd0;
  assign rom_line      = ent_match ? line_idx : 3'd0;
  assign prefetch_busy = (state == ST_SCAN) || (state == ST_WAIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else if (line_end) begin
      // Bank swap happens here regardless of progress; anything unfetched stays invalid.
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (line_start) begin
            idx   <= '0;
            state <= (v_next >= 10'(V_ACTIVE)) ? ST_DONE : ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (ent_match) state <= ST_WAIT;
          else if (last_ent) state <= ST_DONE;
          else idx <= idx + IDX_W'(1);
        end
        ST_WAIT: begin
          if (last_ent) begin
            state <= ST_DONE;
          end else begin
            idx   <= idx + IDX_W'(1);
            state <= ST_SCAN;
          end
        end
        default: state <= ST_DONE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (ent_match) req_col <= ent.loc[3:0];
  end

  logic       bank_hit;
  logic       bank_pix;
`ifdef ENT_COLLISION_EN
  logic       bank_pair;
`endif

  entity_slot_bank #(
    .NUM_ENT(NUM_ENT)
  ) u_bank (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (state == ST_WAIT),
    .wr_idx (idx),
    .wr_col (req_col),
    .wr_row (rom_data),
    .clear  ((state == ST_IDLE) && line_start),
    .swap   (line_end),
    .tc     (tile_of(counter_H)),
    .px     (sub_of(counter_H)),
    .hit    (bank_hit),
    .pix    (bank_pix)
`ifdef ENT_COLLISION_EN
    ,
    .black_pair(bank_pair)
`endif
  );

  // Stage p0 -> p1: pixel colour registered one cycle after the counters.
  logic in_active_p0;
  logic colour_p1;

  assign in_active_p0 = (counter_H < 10'(H_ACTIVE)) && (counter_V < 10'(V_ACTIVE));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) colour_p1 <= 1'b0;
    else        colour_p1 <= in_active_p0 ? (bank_hit ? bank_pix : 1'b1) : 1'b0;
  end

  assign colour = colour_p1;

`ifdef ENT_COLLISION_EN
  logic collision_p1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) collision_p1 <= 1'b0;
    else        collision_p1 <= in_active_p0 && bank_pair;
  end

  assign collision = collision_p1;
`endif

endmodule

// File: tb/tb_entity_scanline_prefetch.sv
// Directed bench for entity_scanline_prefetch: sweeps selected lines, models the sprite ROM, checks colour and requests.
`timescale 1ns/1ps
module tb_entity_scanline_prefetch;

  logic         clk = 1'b0;
  logic         reset;
  logic [111:0] entities;
  logic [9:0]   counter_H;
  logic [9:0]   counter_V;
  logic         rom_req;
  logic [3:0]   rom_sprite_id;
  logic [1:0]   rom_orient;
  logic [2:0]   rom_line;
  logic [7:0]   rom_data;
  logic         colour;
  logic         prefetch_busy;
`ifdef ENT_COLLISION_EN
  logic         collision;
`endif

  entity_scanline_prefetch dut (
    .clk          (clk),
    .reset        (reset),
    .entities     (entities),
    .counter_H    (counter_H),
    .counter_V    (counter_V),
    .rom_req      (rom_req),
    .rom_sprite_id(rom_sprite_id),
    .rom_orient   (rom_orient),
    .rom_line     (rom_line),
    .rom_data     (rom_data),
    .colour       (colour),
    .prefetch_busy(prefetch_busy)
`ifdef ENT_COLLISION_EN
    ,
    .collision    (collision)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sprite ROM model: row = {line, orient, id[2:0]} ^ 8'hA5, returned one cycle after the strobe.
  function automatic logic [7:0] rom_fn(input logic [2:0] id, input logic [1:0] o, input logic [2:0] ln);
    return {ln, o, id} ^ 8'hA5;
  endfunction

  always @(posedge clk) rom_data <= rom_req ? rom_fn(rom_sprite_id[2:0], rom_orient, rom_line) : 8'h00;

  int         req_cnt, busy_cnt;
  int         first_h, last_h;
  logic [3:0] first_id, last_id;
  logic [1:0] last_orient;
  logic [2:0] last_line;

  always @(negedge clk) begin
    if (rom_req) begin
      if (req_cnt == 0) begin
        first_h  = int'(counter_H);
        first_id = rom_sprite_id;
      end
      last_h      = int'(counter_H);
      last_id     = rom_sprite_id;
      last_orient = rom_orient;
      last_line   = rom_line;
      req_cnt++;
    end
    if (prefetch_busy) busy_cnt++;
  end

  task automatic clr_mon();
    req_cnt  = 0;
    busy_cnt = 0;
    first_h  = -1;
    last_h   = -1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_ents();
    entities = {8{14'h3C00}};
  endtask

  task automatic put_ent(input int k, input logic [3:0] id, input logic [1:0] o, input logic [7:0] loc);
    entities[k*14 +: 14] = {id, o, loc};
  endtask

  logic exp_col  [800];
  logic exp_coll [800];

  task automatic exp_line(input int v);
    for (int h = 0; h < 800; h++) begin
      exp_col[h]  = (v < 480) && (h < 640);
      exp_coll[h] = 1'b0;
    end
  endtask

  task automatic exp_tile(input int col, input logic [7:0] row);
    for (int p = 0; p < 40; p++) exp_col[col*40 + p] = row[p/5];
  endtask

  task automatic exp_pair(input int col, input logic [7:0] a, input logic [7:0] b);
    for (int p = 0; p < 40; p++) exp_coll[col*40 + p] = ~a[p/5] & ~b[p/5];
  endtask

  task automatic run_span(input int v, input int h0, input int h1);
    for (int h = h0; h <= h1; h++) begin
      counter_V = 10'(v);
      counter_H = 10'(h);
      tick();
      chk($sformatf("colour v%0d h%0d", v, h), 32'(colour), 32'(exp_col[h]));
`ifdef ENT_COLLISION_EN
      chk($sformatf("collision v%0d h%0d", v, h), 32'(collision), 32'(exp_coll[h]));
`endif
    end
  endtask

  logic [7:0] rows6 [8];

  initial begin
    rows6 = '{8'h85, 8'h8C, 8'h97, 8'h9E, 8'h81, 8'h88, 8'h93, 8'h9A};
    reset     = 1'b0;
    rom_data  = 8'h00;
    counter_H = 10'd600;
    counter_V = 10'd10;
    clr_ents();
    clr_mon();

    // Reset held through the active tail and H_ACTIVE, released mid-blank.
    put_ent(0, 4'd1, 2'd0, 8'd2);
    tick();
    chk("rst colour", 32'(colour), 32'd0);
    chk("rst rom_req", 32'(rom_req), 32'd0);
    chk("rst busy", 32'(prefetch_busy), 32'd0);
    chk("rst rom_fields", {25'd0, rom_sprite_id, rom_orient, rom_line}, 32'd0);
    exp_line(480);
    run_span(10, 600, 699);
    reset = 1'b1;
    run_span(10, 700, 799);
    chk("rst no req", 32'(req_cnt), 32'd0);
    chk("rst no busy", 32'(busy_cnt), 32'd0);

    // First line after reset: no hits; the prefetch for line 12 starts right after H_ACTIVE.
    clr_mon();
    exp_line(11);
    run_span(11, 0, 799);
    chk("l11 req_cnt", 32'(req_cnt), 32'd1);
    chk("l11 first_h", 32'(first_h), 32'd641);
    chk("l11 id", 32'(last_id), 32'd1);
    chk("l11 orient", 32'(last_orient), 32'd0);
    chk("l11 line", 32'(last_line), 32'd2);
    chk("l11 busy", 32'(busy_cnt), 32'd9);

    clr_mon();
    clr_ents();
    exp_line(12);
    exp_tile(2, 8'hE4);
    run_span(12, 0, 799);
    chk("l12 req_cnt", 32'(req_cnt), 32'd0);

    // Single entity on tile 17 fetched on line 39 for line 40.
    clr_mon();
    put_ent(1, 4'd2, 2'd1, 8'd17);
    exp_line(39);
    run_span(39, 0, 799);
    chk("l39 req_cnt", 32'(req_cnt), 32'd1);
    chk("l39 id", 32'(last_id), 32'd2);
    chk("l39 orient", 32'(last_orient), 32'd1);
    chk("l39 line", 32'(last_line), 32'd0);

    clr_mon();
    clr_ents();
    exp_line(40);
    exp_tile(1, 8'hAF);
    run_span(40, 0, 799);
    chk("l40 req_cnt", 32'(req_cnt), 32'd0);

    // All eight channels on tile row 0.
    clr_mon();
    for (int k = 0; k < 8; k++) put_ent(k, 4'(k), 2'(k), 8'(k));
    exp_line(5);
    run_span(5, 0, 799);
    chk("l5 req_cnt", 32'(req_cnt), 32'd8);
    chk("l5 busy", 32'(busy_cnt), 32'd16);
    chk("l5 first_h", 32'(first_h), 32'd641);
    chk("l5 req_span", 32'(last_h - first_h), 32'd14);
    chk("l5 last_id", 32'(last_id), 32'd7);
    chk("l5 line", 32'(last_line), 32'd1);

    // Off-playfield location and unused ID are never requested.
    clr_mon();
    clr_ents();
    put_ent(0, 4'd1, 2'd0, 8'd200);
    put_ent(1, 4'hF, 2'd1, 8'd4);
    exp_line(6);
    for (int k = 0; k < 8; k++) exp_tile(k, rows6[k]);
    run_span(6, 0, 799);
    chk("l6 req_cnt", 32'(req_cnt), 32'd0);

    clr_mon();
    clr_ents();
    exp_line(7);
    run_span(7, 0, 799);
    chk("l7 req_cnt", 32'(req_cnt), 32'd0);

    // Last line of the frame prefetches line 0; two entities share tile 3.
    clr_mon();
    put_ent(2, 4'd3, 2'd0, 8'd3);
    put_ent(5, 4'd6, 2'd2, 8'd3);
    exp_line(524);
    run_span(524, 0, 799);
    chk("l524 req_cnt", 32'(req_cnt), 32'd2);
    chk("l524 first_id", 32'(first_id), 32'd3);
    chk("l524 last_id", 32'(last_id), 32'd6);
    chk("l524 line", 32'(last_line), 32'd0);
    chk("l524 busy", 32'(busy_cnt), 32'd10);

    clr_mon();
    clr_ents();
    exp_line(0);
    exp_tile(3, 8'hA6);
    exp_pair(3, 8'hA6, 8'hB3);
    run_span(0, 0, 799);
    chk("l0 req_cnt", 32'(req_cnt), 32'd0);

    // Line 479 targets blank line 480: no fetch at all.
    clr_mon();
    put_ent(0, 4'd1, 2'd0, 8'd192);
    put_ent(3, 4'd2, 2'd0, 8'd0);
    exp_line(479);
    run_span(479, 0, 799);
    chk("l479 req_cnt", 32'(req_cnt), 32'd0);
    chk("l479 busy", 32'(busy_cnt), 32'd0);

    clr_mon();
    clr_ents();
    exp_line(480);
    run_span(480, 0, 799);
    chk("l480 req_cnt", 32'(req_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
